// File: rtl/muldiv_hilo.sv
// Iterative MIPS32 multiply/divide unit with architectural HI/LO registers.
// One shift-add (mult) or restoring shift-subtract (div) step per cycle on magnitudes, sign fixed at the end.
module muldiv_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] HiLoWData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic               signed_op_c;
    logic               div_zero_c;
    logic [WIDTH-1:0]   a_abs_c;
    logic [WIDTH-1:0]   b_abs_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     div_shift_c;
    logic [WIDTH-1:0]   div_diff_c;
    logic               div_ge_c;
    logic [2*WIDTH-1:0] prod_fix_c;
    logic [WIDTH-1:0]   quo_fix_c;
    logic [WIDTH-1:0]   rem_fix_c;

    // Operand conditioning at launch: magnitudes for signed ops, raw values for unsigned.
    always_comb begin
        signed_op_c = ~Op[0];
        div_zero_c  = Op[1] && (B == '0);
        a_abs_c     = (signed_op_c && A[WIDTH-1]) ? WIDTH'(-A) : A;
        b_abs_c     = (signed_op_c && B[WIDTH-1]) ? WIDTH'(-B) : B;
    end

    // One iteration step; acc holds {partial, multiplier} for mult and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum_c   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        div_shift_c = acc[2*WIDTH-1:WIDTH-1];
        div_ge_c    = div_shift_c >= {1'b0, mcand};
        div_diff_c  = WIDTH'(div_shift_c - {1'b0, mcand});
        prod_fix_c  = neg_res ? (2*WIDTH)'(-acc) : acc;
        quo_fix_c   = neg_res ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix_c   = neg_rem ? WIDTH'(-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (Start) next_state = div_zero_c ? S_DONE : S_CALC;
            S_CALC: if (count == '0) next_state = S_FIX;
            S_FIX:  next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State, status flags and datapath registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            state     <= next_state;
            Busy      <= (next_state != S_IDLE);
            Done      <= (next_state == S_DONE);
            DivByZero <= (state == S_IDLE) && Start && div_zero_c;
            case (state)
                S_IDLE: begin
                    if (HiWrite) Hi <= HiLoWData;
                    if (LoWrite) Lo <= HiLoWData;
                    if (Start) begin
                        is_div  <= Op[1];
                        neg_res <= signed_op_c && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem <= signed_op_c && A[WIDTH-1];
                        count   <= CW'(WIDTH - 1);
                        if (Op[1]) begin
                            mcand <= b_abs_c;
                            acc   <= {{WIDTH{1'b0}}, a_abs_c};
                        end else begin
                            mcand <= a_abs_c;
                            acc   <= {{WIDTH{1'b0}}, b_abs_c};
                        end
                        // Divide-by-zero result overrides any same-edge mthi/mtlo
                        if (div_zero_c) begin
                            Hi <= A;
                            Lo <= '1;
                        end
                    end
                end
                S_CALC: begin
                    count <= count - CW'(1);
                    if (is_div)
                        acc <= {(div_ge_c ? div_diff_c : div_shift_c[WIDTH-1:0]),
                                acc[WIDTH-2:0], div_ge_c};
                    else
                        acc <= {mul_sum_c, acc[WIDTH-1:1]};
                end
                S_FIX: begin
                    if (is_div) begin
                        Hi <= rem_fix_c;
                        Lo <= quo_fix_c;
                    end else begin
                        {Hi, Lo} <= prod_fix_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS32 datapath.
- Sits directly downstream of the register file: its operands are regfile ReadData1/ReadData2 (rs, rt).
- Its Hi/Lo outputs feed the mfhi/mflo path back into regfile WriteData.
- The control unit stalls the pipeline while Busy=1.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count = WIDTH. Only 32 is verified.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  launch operation; sampled only in IDLE
- Op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with Start
- A  input  WIDTH  rs operand (regfile ReadData1)
- B  input  WIDTH  rt operand (regfile ReadData2)
- HiWrite  input  1  mthi: load Hi from HiLoWData
- LoWrite  input  1  mtlo: load Lo from HiLoWData
- HiLoWData  input  WIDTH  data for mthi/mtlo
- Busy  output  1  high whenever state != IDLE
- Done  output  1  one-cycle pulse; Hi/Lo valid with new result
- DivByZero  output  1  pulses with Done when a div/divu had B==0
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation):
  - state=IDLE; Hi=Lo=0; Busy=Done=DivByZero=0.
  - Internal accumulator, operand and counter registers are cleared.
- State machine: IDLE, CALC, FIX, DONE.
- IDLE, Start=1 sampled at edge E0:
  - Latch Op and abs values of A and B. Abs applies for signed ops only; record the result sign and dividend sign. Counter=WIDTH-1.
  - Normal case: go to CALC.
  - div/divu with B==0: go straight to DONE. At E0, Hi=A and Lo=all-ones. Done=DivByZero=1 in the cycle after E0.
- CALC, one iteration per edge, WIDTH edges (E1..E32):
  - Multiply: unsigned shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient and remainder are WIDTH bits each.
  - Counter decrements each edge; at 0, go to FIX.
- FIX, edge E33:
  - Apply sign correction:
    - mult: negate the 2*WIDTH product if the operand signs differ.
    - div: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write Hi/Lo:
    - mult/multu: Hi = product[63:32], Lo = product[31:0].
    - div/divu: Lo = quotient, Hi = remainder.
  - Go to DONE.
- DONE: Done=1 for exactly this cycle. Next edge (E34) goes to IDLE.
  - Total latency: Start edge to Done-high cycle = 34 cycles.
  - Divide-by-zero: Done-high in the cycle after E0.
- Overflow case: div 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0, no flag. This falls out of the abs/negate arithmetic modulo 2^32.
- Start while Busy=1 (including the DONE cycle): ignored; the operation in flight is unaffected.
- HiWrite/LoWrite:
  - Honoured only in IDLE; ignored while Busy.
  - Both together: Hi and Lo both load HiLoWData.
  - Simultaneous with Start in IDLE: the write lands at E0, and the operation result later overwrites it at E33 (or at E0 for divide-by-zero, where the divide result wins).
- Hi/Lo hold their values at all times except on reset, a write, or a result commit. Outputs are registered; there is no combinational path from inputs to outputs.
- A and B may change after E0 without effect.

Test Plan:
- multu A=0xFFFFFFFF B=0xFFFFFFFF, Start at E0 -> Busy E0..E34, Done high in cycle 34 only, Hi=0xFFFFFFFE Lo=0x00000001, DivByZero=0.
- mult A=0xFFFFFFFD (-3) B=5 -> Hi=0xFFFFFFFF Lo=0xFFFFFFF1. Then div A=0xFFFFFFF9 (-7) B=2 -> Lo=0xFFFFFFFD Hi=0xFFFFFFFF.
- divu A=100 B=0 -> Done and DivByZero high in the cycle after Start, Hi=0x00000064 Lo=0xFFFFFFFF, Busy low two cycles after Start.
- div A=0x80000000 B=0xFFFFFFFF -> Lo=0x80000000 Hi=0x00000000, no flag. divu A=0xFFFFFFFF B=0x10 -> Lo=0x0FFFFFFF Hi=0xF.
- In IDLE, HiWrite=1 with HiLoWData=0x1234 -> Hi=0x1234. Then start mult 2*3 and pulse Start (multu 7*7) plus LoWrite at cycle 5 -> both ignored; result Hi=0 Lo=6 at cycle 34.
- Start multu 9*9, assert Reset at cycle 10 -> next cycle Busy=0, Hi=Lo=0, no Done pulse. A fresh multu 9*9 then yields Lo=81 at latency 34.
